// File: rtl/tl_memory_master_adapter.sv
// tl_memory_master_adapter
// Bridges a simple single-beat memory request/response port onto a
// TileLink-UL master (channels A and D). One transaction is in flight at
// a time; a missing D response is turned into an error after TIMEOUT
// cycles of waiting.
//
// Ports
//   clk_i, reset_i        clock, synchronous active-low reset
//   req_*                 upstream request (valid/ready, write, addr, size, wr_data)
//   resp_*                upstream response (valid/ready, rd_data, error)
//   a_*                   TileLink-UL channel A (master -> slave)
//   d_*                   TileLink-UL channel D (slave -> master)
module tl_memory_master_adapter #(
    parameter int unsigned SOURCE_W  = 4,
    parameter int unsigned SOURCE_ID = 0,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                clk_i,
    input  logic                reset_i,

    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_write_i,
    input  logic [31:0]         req_addr_i,
    input  logic [1:0]          req_size_i,
    input  logic [31:0]         req_wr_data_i,

    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [31:0]         resp_rd_data_o,
    output logic                resp_error_o,

    output logic                a_valid,
    input  logic                a_ready,
    output logic [2:0]          a_opcode,
    output logic [2:0]          a_param,
    output logic [1:0]          a_size,
    output logic [SOURCE_W-1:0] a_source,
    output logic [31:0]         a_address,
    output logic [3:0]          a_mask,
    output logic [31:0]         a_data,

    input  logic                d_valid,
    output logic                d_ready,
    input  logic [2:0]          d_opcode,
    input  logic [1:0]          d_param,
    input  logic [1:0]          d_size,
    input  logic [SOURCE_W-1:0] d_source,
    input  logic [31:0]         d_data,
    input  logic                d_error
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] OP_PUT_FULL   = 3'd0;
    localparam logic [2:0] OP_GET        = 3'd4;
    localparam logic [2:0] OP_ACK        = 3'd0;
    localparam logic [2:0] OP_ACK_DATA   = 3'd1;
    localparam logic [SOURCE_W-1:0] SRC  = SOURCE_W'(SOURCE_ID);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_A = 2'd1,
        WAIT_D = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               write_q, write_d;
    logic [31:0]        addr_q, addr_d;
    logic [1:0]         size_q, size_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               d_match;
    logic               cnt_expired;
    logic [2:0]         exp_d_opcode;

    // D beat addressed to this master (only meaningful while waiting).
    assign d_match      = d_valid && (d_source == SRC);
    assign exp_d_opcode = write_q ? OP_ACK : OP_ACK_DATA;
    // The current WAIT_D cycle is the TIMEOUT-th one without a response.
    assign cnt_expired  = (32'(cnt_q) + 32'd1) >= 32'(TIMEOUT);

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    write_d = req_write_i;
                    addr_d  = req_addr_i;
                    size_d  = req_size_i;
                    wdata_d = req_wr_data_i;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    // Reserved size is rejected locally without touching the bus.
                    if (req_size_i == 2'd3) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = SEND_A;
                    end
                end
            end
            SEND_A: begin
                if (a_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT_D;
                end
            end
            WAIT_D: begin
                if (d_match) begin
                    rdata_d = write_q ? 32'd0 : d_data;
                    err_d   = d_error || (d_opcode != exp_d_opcode);
                    state_d = RESP;
                end else if (cnt_expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    // Foreign-source beats are swallowed here and still count as waiting.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs decode straight from the state register.
    assign req_ready_o    = (state_q == IDLE);
    assign a_valid        = (state_q == SEND_A);
    assign d_ready        = (state_q == WAIT_D);
    assign resp_valid_o   = (state_q == RESP);
    assign resp_rd_data_o = rdata_q;
    assign resp_error_o   = err_q;

    // Channel A payload comes only from the captured request, so it is
    // stable for as long as a_valid waits on a_ready.
    assign a_opcode  = write_q ? OP_PUT_FULL : OP_GET;
    assign a_param   = 3'd0;
    assign a_size    = size_q;
    assign a_source  = SRC;
    assign a_address = addr_q;
    assign a_data    = write_q ? wdata_q : 32'd0;

    // Low-lane mask, never shifted by the address offset.
    always_comb begin
        a_mask = 4'b1111;
        case (size_q)
            2'd0:    a_mask = 4'b0001;
            2'd1:    a_mask = 4'b0011;
            default: a_mask = 4'b1111;
        endcase
    end

    // D-channel param/size carry nothing this adapter needs.
    logic unused_d_fields;
    assign unused_d_fields = ^{d_param, d_size};

endmodule

// File: tb/tb_tl_memory_master_adapter.sv
// Self-checking bench for tl_memory_master_adapter: directed vector table,
// hand-written reset sequences and randomized transactions checked against
// a rule-level reference model.
module tb_tl_memory_master_adapter;

    localparam int unsigned SW  = 4;
    localparam int unsigned SRC = 5;
    localparam int unsigned TMO = 4;
    localparam logic [SW-1:0] SRC_V   = SW'(SRC);
    localparam logic [SW-1:0] WRONG_V = SW'(SRC ^ 1);

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          req_valid_i, req_ready_o, req_write_i;
    logic [31:0]   req_addr_i, req_wr_data_i;
    logic [1:0]    req_size_i;
    logic          resp_valid_o, resp_ready_i, resp_error_o;
    logic [31:0]   resp_rd_data_o;
    logic          a_valid, a_ready;
    logic [2:0]    a_opcode, a_param;
    logic [1:0]    a_size;
    logic [SW-1:0] a_source;
    logic [31:0]   a_address, a_data;
    logic [3:0]    a_mask;
    logic          d_valid, d_ready, d_error;
    logic [2:0]    d_opcode;
    logic [1:0]    d_param, d_size;
    logic [SW-1:0] d_source;
    logic [31:0]   d_data;

    always #5 clk_i = ~clk_i;

    tl_memory_master_adapter #(
        .SOURCE_W (SW),
        .SOURCE_ID(SRC),
        .TIMEOUT  (TMO)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_wr_data_i(req_wr_data_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rd_data_o(resp_rd_data_o), .resp_error_o(resp_error_o),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_data(d_data), .d_error(d_error)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        int          a_dly;   // cycles a_ready held low
        int          d_dly;   // idle WAIT_D cycles before the D beat(s)
        bit          wrong;   // foreign-source beat before the real one
        bit          tmo;     // slave never answers
        logic [2:0]  d_op;
        logic        d_err;
        logic [31:0] d_data;
        int          r_dly;   // cycles resp_ready_i held low
        logic [2:0]  e_op;
        logic [3:0]  e_mask;
        logic [31:0] e_adata;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk1(input string tag, input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %b expected %b", tag, nm, act, exp);
        end
    endtask

    task automatic chk32(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %h expected %h", tag, nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [1:0] s,
                                input logic [31:0] wd, input int ad, input int dd,
                                input bit wr, input bit tm, input logic [2:0] dop,
                                input logic de, input logic [31:0] ddat, input int rd,
                                input logic [2:0] eop, input logic [3:0] em,
                                input logic [31:0] ead, input logic [31:0] erd,
                                input logic ee);
        vec_t v;
        v.write = w; v.addr = a; v.size = s; v.wdata = wd;
        v.a_dly = ad; v.d_dly = dd; v.wrong = wr; v.tmo = tm;
        v.d_op = dop; v.d_err = de; v.d_data = ddat; v.r_dly = rd;
        v.e_op = eop; v.e_mask = em; v.e_adata = ead; v.e_rdata = erd; v.e_err = ee;
        return v;
    endfunction

    // Reference model: expected bus fields and response from the protocol rules.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        logic [2:0] want_op;
        r = v;
        r.e_op    = v.write ? 3'd0 : 3'd4;
        r.e_mask  = 4'((32'd1 << (32'd1 << v.size)) - 32'd1);
        r.e_adata = v.write ? v.wdata : 32'd0;
        want_op   = v.write ? 3'd0 : 3'd1;
        if (v.size == 2'd3 || v.tmo) begin
            r.e_rdata = 32'd0;
            r.e_err   = 1'b1;
        end else begin
            r.e_rdata = v.write ? 32'd0 : v.d_data;
            r.e_err   = v.d_err || (v.d_op != want_op);
        end
        return r;
    endfunction

    task automatic chk_a(input vec_t v, input string tag);
        chk1 (tag, "a_valid",   a_valid, 1'b1);
        chk32(tag, "a_opcode",  32'(a_opcode), 32'(v.e_op));
        chk32(tag, "a_param",   32'(a_param), 32'd0);
        chk32(tag, "a_size",    32'(a_size), 32'(v.size));
        chk32(tag, "a_source",  32'(a_source), 32'(SRC));
        chk32(tag, "a_address", a_address, v.addr);
        chk32(tag, "a_mask",    32'(a_mask), 32'(v.e_mask));
        chk32(tag, "a_data",    a_data, v.e_adata);
        chk1 (tag, "d_ready_in_a", d_ready, 1'b0);
    endtask

    task automatic stray_d();
        d_valid  = 1'b1;
        d_source = SRC_V;
        d_opcode = 3'd1;
        d_error  = 1'b1;
        d_data   = $urandom();
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        int k;
        @(negedge clk_i);
        chk1(tag, "req_ready_idle", req_ready_o, 1'b1);
        req_valid_i   = 1'b1;
        req_write_i   = v.write;
        req_addr_i    = v.addr;
        req_size_i    = v.size;
        req_wr_data_i = v.wdata;
        @(negedge clk_i);
        // Scramble request inputs: the adapter must use its captured copy.
        req_valid_i   = 1'b0;
        req_write_i   = ~v.write;
        req_addr_i    = $urandom();
        req_size_i    = 2'($urandom_range(0, 3));
        req_wr_data_i = $urandom();
        chk1(tag, "req_ready_busy", req_ready_o, 1'b0);
        if (v.size != 2'd3) begin
            for (int i = 0; i <= v.a_dly; i++) begin
                chk_a(v, tag);
                if (i < v.a_dly) begin
                    stray_d();
                    @(negedge clk_i);
                end
            end
            d_valid = 1'b0;
            d_error = 1'b0;
            a_ready = 1'b1;
            @(negedge clk_i);
            a_ready = 1'b0;
            chk1(tag, "a_valid_after_hs", a_valid, 1'b0);
            chk1(tag, "d_ready_wait",     d_ready, 1'b1);
            if (v.tmo) begin
                k = 0;
                while (!resp_valid_o && k < 3 * int'(TMO)) begin
                    @(negedge clk_i);
                    k++;
                end
                chk32(tag, "timeout_cycles", 32'(k), 32'(TMO));
            end else begin
                for (int i = 0; i < v.d_dly; i++) @(negedge clk_i);
                chk1(tag, "resp_early", resp_valid_o, 1'b0);
                if (v.wrong) begin
                    d_valid  = 1'b1;
                    d_source = WRONG_V;
                    d_opcode = v.d_op;
                    d_error  = 1'b0;
                    d_data   = ~v.d_data;
                    @(negedge clk_i);
                    chk1(tag, "resp_after_wrong_src", resp_valid_o, 1'b0);
                    chk1(tag, "d_ready_after_wrong",  d_ready, 1'b1);
                end
                d_valid  = 1'b1;
                d_source = SRC_V;
                d_opcode = v.d_op;
                d_error  = v.d_err;
                d_data   = v.d_data;
                d_param  = 2'd0;
                d_size   = v.size;
                @(negedge clk_i);
                d_valid  = 1'b0;
                d_error  = 1'b0;
            end
        end
        chk1(tag, "resp_valid",   resp_valid_o, 1'b1);
        chk1(tag, "a_valid_resp", a_valid, 1'b0);
        chk1(tag, "d_ready_resp", d_ready, 1'b0);
        for (int i = 0; i <= v.r_dly; i++) begin
            chk32(tag, "resp_rd_data", resp_rd_data_o, v.e_rdata);
            chk1 (tag, "resp_error",   resp_error_o, v.e_err);
            chk1 (tag, "resp_valid_hold", resp_valid_o, 1'b1);
            chk1 (tag, "req_ready_resp",  req_ready_o, 1'b0);
            if (i < v.r_dly) begin
                stray_d();
                @(negedge clk_i);
            end
        end
        d_valid      = 1'b0;
        d_error      = 1'b0;
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        chk1(tag, "resp_valid_done", resp_valid_o, 1'b0);
        chk1(tag, "req_ready_done",  req_ready_o, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1 (tag, "rst_req_ready",  req_ready_o, 1'b1);
        chk1 (tag, "rst_a_valid",    a_valid, 1'b0);
        chk1 (tag, "rst_d_ready",    d_ready, 1'b0);
        chk1 (tag, "rst_resp_valid", resp_valid_o, 1'b0);
        chk32(tag, "rst_rd_data",    resp_rd_data_o, 32'd0);
        chk1 (tag, "rst_error",      resp_error_o, 1'b0);
    endtask

    // ph: 0 = reset in SEND_A, 1 = in WAIT_D, 2 = in RESP
    task automatic reset_mid(input int ph, input string tag);
        @(negedge clk_i);
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h300; req_size_i = 2'd2;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        if (ph >= 1) begin
            a_ready = 1'b1;
            @(negedge clk_i);
            a_ready = 1'b0;
            chk1(tag, "pre_d_ready", d_ready, 1'b1);
        end
        if (ph == 2) begin
            d_valid = 1'b1; d_source = SRC_V; d_opcode = 3'd1; d_error = 1'b1; d_data = 32'hA5A5_0F0F;
            @(negedge clk_i);
            d_valid = 1'b0; d_error = 1'b0;
            chk32(tag, "pre_rd_data", resp_rd_data_o, 32'hA5A5_0F0F);
        end
        // Reset while every handshake the state could take is offered.
        reset_i = 1'b0;
        a_ready = 1'b1; resp_ready_i = 1'b0;
        d_valid = 1'b1; d_source = SRC_V; d_opcode = 3'd1; d_error = 1'b1; d_data = 32'h1234_5678;
        @(negedge clk_i);
        reset_i = 1'b1;
        a_ready = 1'b0;
        chk_reset_outputs(tag);
        @(negedge clk_i);
        d_valid = 1'b0; d_error = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk1(tag, "no_resp_after_rst",  resp_valid_o, 1'b0);
            chk1(tag, "no_a_after_rst",     a_valid, 1'b0);
            chk1(tag, "idle_after_rst",     req_ready_o, 1'b1);
            @(negedge clk_i);
        end
    endtask

    vec_t tbl[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        tbl[0] = mk(1'b0, 32'h100,  2'd2, 32'h0,        0, 2, 1'b0, 1'b0, 3'd1, 1'b0, 32'hDEADBEEF, 0, 3'd4, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0);
        tbl[1] = mk(1'b1, 32'h203,  2'd0, 32'h5A,       0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h12345678, 0, 3'd0, 4'h1, 32'h5A,       32'h0,        1'b0);
        tbl[2] = mk(1'b1, 32'h1002, 2'd1, 32'hCAFEF00D, 5, 1, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0,        3, 3'd0, 4'h3, 32'hCAFEF00D, 32'h0,        1'b0);
        tbl[3] = mk(1'b0, 32'h40,   2'd2, 32'h0,        0, 0, 1'b1, 1'b0, 3'd1, 1'b1, 32'h11,       0, 3'd4, 4'hF, 32'h0,        32'h11,       1'b1);
        tbl[4] = mk(1'b0, 32'h41,   2'd0, 32'h0,        1, 0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h77,       0, 3'd4, 4'h1, 32'h0,        32'h77,       1'b1);
        tbl[5] = mk(1'b1, 32'h80,   2'd2, 32'h0BADF00D, 0, 0, 1'b0, 1'b0, 3'd1, 1'b0, 32'h99,       1, 3'd0, 4'hF, 32'h0BADF00D, 32'h0,        1'b1);
        tbl[6] = mk(1'b0, 32'h500,  2'd2, 32'h0,        0, 0, 1'b0, 1'b1, 3'd1, 1'b0, 32'h0,        0, 3'd4, 4'hF, 32'h0,        32'h0,        1'b1);
        tbl[7] = mk(1'b1, 32'h600,  2'd3, 32'hFFFF,     0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0,        1, 3'd0, 4'hF, 32'hFFFF,     32'h0,        1'b1);
        tbl[8] = mk(1'b0, 32'h2,    2'd1, 32'h0,        0, 3, 1'b0, 1'b0, 3'd1, 1'b0, 32'h0000BEEF, 0, 3'd4, 4'h3, 32'h0,        32'h0000BEEF, 1'b0);
        tbl[9] = mk(1'b0, 32'h4,    2'd2, 32'h0,        2, 2, 1'b1, 1'b0, 3'd1, 1'b0, 32'h13579BDF, 2, 3'd4, 4'hF, 32'h0,        32'h13579BDF, 1'b0);

        reset_i = 1'b0;
        req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_size_i = '0; req_wr_data_i = '0;
        resp_ready_i = 1'b0; a_ready = 1'b0;
        d_valid = 1'b0; d_opcode = '0; d_param = '0; d_size = '0; d_source = '0; d_data = '0; d_error = 1'b0;
        repeat (3) @(negedge clk_i);
        chk_reset_outputs("por");
        reset_i = 1'b1;

        for (int i = 0; i < 10; i++) do_txn(tbl[i], $sformatf("vec%0d", i));

        reset_mid(0, "rst_send_a");
        reset_mid(1, "rst_wait_d");
        reset_mid(2, "rst_resp");

        for (int i = 0; i < 40; i++) begin
            v.write  = 1'($urandom_range(0, 1));
            v.addr   = $urandom();
            v.size   = 2'($urandom_range(0, 3));
            v.wdata  = $urandom();
            v.a_dly  = int'($urandom_range(0, 3));
            v.tmo    = ($urandom_range(0, 7) == 0);
            v.wrong  = 1'($urandom_range(0, 1));
            v.d_dly  = int'($urandom_range(0, v.wrong ? 2 : 3));
            v.d_op   = 3'($urandom_range(0, 1));
            v.d_err  = ($urandom_range(0, 3) == 0);
            v.d_data = $urandom();
            v.r_dly  = int'($urandom_range(0, 2));
            v = model(v);
            do_txn(v, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tl_memory_master_adapter.md
TL_MEMORY_MASTER_ADAPTER -- requirements
Module: tl_memory_master_adapter

Interface
REQ-001 SHALL have parameters: SOURCE_ID, default 0, TileLink source tag driven on a_source and matched on d_source; TIMEOUT, default 255, max cycles waiting for D before error.
REQ-002 SHALL have ports: clk_i  in  1  clock; reset_i  in  1  reset, synchronous, active-low.
REQ-003 SHALL have upstream request ports: req_valid_i in 1; req_ready_o out 1; req_write_i in 1 (1=write); req_addr_i in 32; req_size_i in 2 (0=byte,1=half,2=word,3=reserved); req_wr_data_i in 32.
REQ-004 SHALL have upstream response ports: resp_valid_o out 1; resp_ready_i in 1; resp_rd_data_o out 32; resp_error_o out 1.
REQ-005 SHALL have TileLink-UL master A ports: a_valid out 1; a_ready in 1; a_opcode out 3; a_param out 3; a_size out 2; a_source out per source width; a_address out 32; a_mask out 4; a_data out 32.
REQ-006 SHALL have TileLink-UL master D ports: d_valid in 1; d_ready out 1; d_opcode in 3; d_param in 2; d_size in 2; d_source in per source width; d_data in 32; d_error in 1.

Function
REQ-007 SHALL implement FSM states IDLE, SEND_A, WAIT_D, RESP; only one transaction outstanding.
REQ-008 IDLE: req_ready_o=1, all other handshake outputs 0; on req_valid_i&&req_ready_o SHALL register write, addr, size, wr_data and go to SEND_A, or to RESP with error=1 if req_size_i==3 (no A beat issued).
REQ-009 SEND_A: a_valid=1, fields from registered request, held stable until a_ready; a_valid&&a_ready SHALL move to WAIT_D.
REQ-010 a_opcode SHALL be 4 (Get) for reads, 0 (PutFullData) for writes; a_param=0; a_source=SOURCE_ID; a_size=registered size; a_address=registered address unmodified.
REQ-011 a_mask SHALL be 4'b0001 byte, 4'b0011 half, 4'b1111 word (low lanes, unshifted); a_data SHALL be wr_data for writes, 0 for reads.
REQ-012 WAIT_D: d_ready=1; beat with d_source!=SOURCE_ID SHALL be consumed and discarded, state unchanged.
REQ-013 Matching beat SHALL move to RESP capturing rd_data=d_data for reads (0 for writes) and error=d_error OR opcode mismatch (read expects 1 AccessAckData, write expects 0 AccessAck).
REQ-014 Timeout counter SHALL clear on entering WAIT_D, increment each WAIT_D cycle without matching beat; reaching TIMEOUT SHALL move to RESP with error=1, rd_data=0; later stray D beats consumed only in WAIT_D.
REQ-015 RESP: resp_valid_o=1 with captured data/error held stable until resp_ready_i; handshake SHALL return to IDLE; req_ready_o=0 in RESP.
REQ-016 Latency: request accepted cycle N -> a_valid cycle N+1; matching D beat cycle M -> resp_valid_o cycle M+1; zero-wait round trip minimum 3 cycles request-to-response.
REQ-017 A beat and D beat SHALL never be accepted in the same cycle (D ignored outside WAIT_D, d_ready=0).

Reset
REQ-018 reset_i low at clk_i edge SHALL force IDLE, clear counter, captured data and error to 0, overriding any handshake that cycle.
REQ-019 During/after reset: req_ready_o=1 (IDLE), a_valid=0, d_ready=0, resp_valid_o=0, resp_rd_data_o=0, resp_error_o=0.
REQ-020 Reset mid-transaction SHALL abandon it without response; an in-flight A beat is dropped.

Verification
REQ-021 Read word addr 0x100, slave a_ready=1, AccessAckData d_data=0xDEADBEEF after 2 cycles -> a_opcode=4, a_mask=1111, resp_rd_data_o=0xDEADBEEF, resp_error_o=0.
REQ-022 Write byte addr 0x203 data 0x5A -> a_opcode=0, a_size=0, a_mask=0001, a_data=0x5A, a_address=0x203; AccessAck -> resp_valid_o, error=0, rd_data=0.
REQ-023 a_ready low 5 cycles -> a_valid and all A fields stable 5 cycles, single A beat; resp_ready_i low 3 cycles -> response held stable, req_ready_o=0.
REQ-024 D beat with wrong source then matching beat with d_error=1 -> first discarded, response error=1; read answered with AccessAck (opcode 0) -> error=1.
REQ-025 TIMEOUT=4, no D beat -> resp_valid_o with error=1 exactly after 4 WAIT_D cycles; req_size_i=3 -> error response, no a_valid.
REQ-026 reset_i low while in WAIT_D -> next cycle IDLE, all outputs at REQ-019 values, no response emitted.
